alu_4bit: RTL and testbench

// - Registered 4-bit integer ALU: 8 ops selected by ALU_Sel; result plus Zero/Carry/Overflow flags.
// - Leaf datapath block in the small-CPU execute stage; operands in, registered result/flags out 1 cycle later.

---
 rtl/alu_4bit_pkg.sv | 23 ++
 rtl/alu_4bit_comb.sv | 54 +++++
 rtl/alu_4bit.sv | 65 ++++++
 tb/tb_alu_4bit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_4bit_pkg.sv
// Shared types for the 4-bit ALU: operation encoding and the flag bundle.
package alu_4bit_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_4bit_comb.sv
// Combinational core of the ALU: decodes the op and produces result plus flags.
module alu_4bit_comb
  import alu_4bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // The extra top bit of diff is the borrow: it is set exactly when a < b.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    flags  = '0;
    case (op)
      OP_ADD: begin
        result         = sum[MSB:0];
        flags.carry    = sum[WIDTH];
        flags.overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result         = diff[MSB:0];
        flags.carry    = diff[WIDTH];
        flags.overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result      = {a[MSB-1:0], 1'b0};
        flags.carry = a[MSB];
      end
      OP_SHR: begin
        result      = {1'b0, a[MSB:1]};
        flags.carry = a[0];
      end
      default: ;
    endcase
    flags.zero = (result == '0);
  end

endmodule

// File: rtl/alu_4bit.sv
// Registered 4-bit ALU with one-cycle latency and result hold when in_valid is low.
// Optional sticky overflow output is enabled by defining ALU_4BIT_STICKY_OVF_EN.
module alu_4bit
  import alu_4bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALU_Sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALU_Result,
  output logic             Zero,
  output logic             Carry,
  output logic             Overflow
`ifdef ALU_4BIT_STICKY_OVF_EN
  ,
  output logic             Ovf_Sticky
`endif
);

  logic [WIDTH-1:0] result_next;
  alu_flags_t       flags_next;

  alu_4bit_comb #(.WIDTH(WIDTH)) u_comb (
    .a      (a),
    .b      (b),
    .op     (alu_op_e'(ALU_Sel)),
    .result (result_next),
    .flags  (flags_next)
  );

  // Zero resets high so that Zero == (ALU_Result == 0) holds through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      ALU_Result <= '0;
      Zero       <= 1'b1;
      Carry      <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ALU_Result <= result_next;
        Zero       <= flags_next.zero;
        Carry      <= flags_next.carry;
        Overflow   <= flags_next.overflow;
      end
    end
  end

`ifdef ALU_4BIT_STICKY_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Ovf_Sticky <= 1'b0;
    end else if (in_valid && flags_next.overflow) begin
      Ovf_Sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// Directed and exhaustive self-checking bench for alu_4bit.
// Covers ALU_4BIT_STICKY_OVF_EN when that macro is defined for the build.
`timescale 1ns/1ps
module tb_alu_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] ALU_Sel;
  logic       out_valid;
  logic [3:0] ALU_Result;
  logic       Zero;
  logic       Carry;
  logic       Overflow;
`ifdef ALU_4BIT_STICKY_OVF_EN
  logic       Ovf_Sticky;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_4bit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .ALU_Sel    (ALU_Sel),
    .out_valid  (out_valid),
    .ALU_Result (ALU_Result),
    .Zero       (Zero),
    .Carry      (Carry),
    .Overflow   (Overflow)
`ifdef ALU_4BIT_STICKY_OVF_EN
    ,
    .Ovf_Sticky (Ovf_Sticky)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got unfinished run, expected completion");
    $fatal(1, "watchdog");
  end

  // Zero must track the registered result on every cycle, reset included.
  always @(negedge clk) begin
    n_checks++;
    if (Zero !== (ALU_Result == 4'd0)) begin
      n_fail++;
      $display("FAIL zero_invariant: Zero=%b ALU_Result=%b", Zero, ALU_Result);
    end
  end

  // Independent integer reference: returns {result[3:0], zero, carry, overflow}.
  function automatic logic [6:0] ref_model(input int ia, input int ib, input int is);
    int r, sa, sb, sr;
    bit c, o;
    c  = 1'b0;
    o  = 1'b0;
    sa = (ia > 7) ? ia - 16 : ia;
    sb = (ib > 7) ? ib - 16 : ib;
    case (is)
      0: begin r = ia + ib; c = (r > 15); sr = sa + sb; o = (sr > 7) || (sr < -8); r = r % 16; end
      1: begin r = (ia - ib + 16) % 16; c = (ia < ib); sr = sa - sb; o = (sr > 7) || (sr < -8); end
      2: r = ia & ib;
      3: r = ia | ib;
      4: r = ia ^ ib;
      5: r = 15 - ia;
      6: begin r = (ia * 2) % 16; c = (ia >= 8); end
      default: begin r = ia / 2; c = (ia % 2) == 1; end
    endcase
    return {r[3:0], (r == 0), c, o};
  endfunction

  task automatic drive(input logic [3:0] ta, input logic [3:0] tbv, input logic [2:0] ts);
    @(negedge clk);
    a        = ta;
    b        = tbv;
    ALU_Sel  = ts;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    $display("txn a=%b b=%b sel=%b -> res=%b Z=%b C=%b V=%b ov=%b",
             ta, tbv, ts, ALU_Result, Zero, Carry, Overflow, out_valid);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a        = 4'($urandom);
      b        = 4'($urandom);
      ALU_Sel  = 3'($urandom);
      in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({ALU_Result, Zero, Carry, Overflow, out_valid} !== 8'b0000_1000) begin
      n_fail++;
      $display("FAIL reset: got res=%b Z=%b C=%b V=%b ov=%b, expected 0000 1 0 0 0",
               ALU_Result, Zero, Carry, Overflow, out_valid);
    end
`ifdef ALU_4BIT_STICKY_OVF_EN
    n_checks++;
    if (Ovf_Sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sticky: got %b expected 0", Ovf_Sticky);
    end
`endif
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_add();
    drive(4'b0111, 4'b0001, 3'b000);
    n_checks++;
    if ({ALU_Result, Zero, Carry, Overflow, out_valid} !== 8'b1000_0011) begin
      n_fail++;
      $display("FAIL add_ovf: got res=%b Z=%b C=%b V=%b ov=%b, expected 1000 0 0 1 1",
               ALU_Result, Zero, Carry, Overflow, out_valid);
    end
    drive(4'b1111, 4'b0001, 3'b000);
    n_checks++;
    if ({ALU_Result, Zero, Carry, Overflow, out_valid} !== 8'b0000_1101) begin
      n_fail++;
      $display("FAIL add_carry: got res=%b Z=%b C=%b V=%b ov=%b, expected 0000 1 1 0 1",
               ALU_Result, Zero, Carry, Overflow, out_valid);
    end
  endtask

  task automatic test_sub();
    drive(4'b1000, 4'b0001, 3'b001);
    n_checks++;
    if ({ALU_Result, Zero, Carry, Overflow} !== 7'b0111_001) begin
      n_fail++;
      $display("FAIL sub_ovf: got res=%b Z=%b C=%b V=%b, expected 0111 0 0 1",
               ALU_Result, Zero, Carry, Overflow);
    end
    drive(4'b0011, 4'b0101, 3'b001);
    n_checks++;
    if ({ALU_Result, Zero, Carry, Overflow} !== 7'b1110_010) begin
      n_fail++;
      $display("FAIL sub_borrow: got res=%b Z=%b C=%b V=%b, expected 1110 0 1 0",
               ALU_Result, Zero, Carry, Overflow);
    end
    drive(4'b1010, 4'b1010, 3'b001);
    n_checks++;
    if ({ALU_Result, Zero, Carry, Overflow} !== 7'b0000_100) begin
      n_fail++;
      $display("FAIL sub_self: got res=%b Z=%b C=%b V=%b, expected 0000 1 0 0",
               ALU_Result, Zero, Carry, Overflow);
    end
  endtask

  task automatic test_logic_shift();
    logic [2:0] sels  [6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [3:0] exp_r [6] = '{4'b1000, 4'b1110, 4'b0110, 4'b0011, 4'b1000, 4'b0110};
    logic       exp_c [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(4'b1100, 4'b1010, sels[i]);
      n_checks++;
      if ({ALU_Result, Carry, Overflow} !== {exp_r[i], exp_c[i], 1'b0}) begin
        n_fail++;
        $display("FAIL logic_sel%b: got res=%b C=%b V=%b, expected %b %b 0",
                 sels[i], ALU_Result, Carry, Overflow, exp_r[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(4'b0111, 4'b0001, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a        = 4'(i * 5 + 3);
      b        = 4'(i + 9);
      ALU_Sel  = 3'(i);
      @(posedge clk);
      #1;
      $display("txn idle a=%b b=%b -> res=%b ov=%b", a, b, ALU_Result, out_valid);
      n_checks++;
      if ({ALU_Result, Zero, Carry, Overflow, out_valid} !== 8'b1000_0010) begin
        n_fail++;
        $display("FAIL hold: got res=%b Z=%b C=%b V=%b ov=%b, expected 1000 0 0 1 0",
                 ALU_Result, Zero, Carry, Overflow, out_valid);
      end
    end
  endtask

  task automatic test_sticky();
`ifdef ALU_4BIT_STICKY_OVF_EN
    drive(4'b0111, 4'b0001, 3'b000);
    drive(4'b0001, 4'b0001, 3'b000);
    n_checks++;
    if ({Overflow, Ovf_Sticky} !== 2'b01) begin
      n_fail++;
      $display("FAIL sticky_hold: got V=%b sticky=%b, expected 0 1", Overflow, Ovf_Sticky);
    end
`else
    $display("txn sticky overflow not built");
`endif
  endtask

  task automatic test_midstream_reset();
    drive(4'b0101, 4'b0110, 3'b000);
    @(negedge clk);
    a        = 4'b1111;
    b        = 4'b1111;
    ALU_Sel  = 3'b011;
    rst_n    = 1'b0;
    #1;
    $display("txn async reset asserted mid-stream");
    n_checks++;
    if ({ALU_Result, Zero, Carry, Overflow, out_valid} !== 8'b0000_1000) begin
      n_fail++;
      $display("FAIL midreset_now: got res=%b Z=%b C=%b V=%b ov=%b, expected 0000 1 0 0 0",
               ALU_Result, Zero, Carry, Overflow, out_valid);
    end
`ifdef ALU_4BIT_STICKY_OVF_EN
    n_checks++;
    if (Ovf_Sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_sticky: got %b expected 0", Ovf_Sticky);
    end
`endif
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({ALU_Result, out_valid} !== 5'b0000_0) begin
      n_fail++;
      $display("FAIL midreset_discard: got res=%b ov=%b, expected 0000 0", ALU_Result, out_valid);
    end
  endtask

  task automatic test_exhaustive();
    logic [6:0] expv;
    int         errs = 0;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int is = 0; is < 8; is++) begin
          @(negedge clk);
          a        = 4'(ia);
          b        = 4'(ib);
          ALU_Sel  = 3'(is);
          in_valid = 1'b1;
          @(posedge clk);
          #1;
          expv = ref_model(ia, ib, is);
          n_checks++;
          if ({ALU_Result, Zero, Carry, Overflow, out_valid} !== {expv, 1'b1}) begin
            n_fail++;
            errs++;
            if (errs <= 10)
              $display("FAIL exhaustive a=%0d b=%0d sel=%0d: got %b%b%b%b ov=%b, expected %b ov=1",
                       ia, ib, is, ALU_Result, Zero, Carry, Overflow, out_valid, expv);
          end
        end
      end
    end
    $display("txn exhaustive sweep of 2048 vectors done");
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    ALU_Sel  = '0;
    test_reset();
    test_add();
    test_sub();
    test_logic_shift();
    test_hold();
    test_sticky();
    test_midstream_reset();
    test_exhaustive();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
